ga_run_controller: RTL and testbench

Parametrised top-level sequencer for the genetic-algorithm run. It sequences the initial-population, selection and mutation engines through a configurable number of generations, and terminates early on a fitness target or an abort. It holds the current population in a register and hands the result to the UART reporter. It sits between the population engines and the UART output path, and supersedes the fixed 2-bit, 30000-generation controller.

---
 rtl/ga_run_controller_if.sv | 42 ++++
 rtl/ga_run_controller.sv | 127 ++++++++++++
 tb/tb_ga_run_controller.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ga_run_controller_if.sv
// Control and data bundle between the GA run sequencer and its engines / UART reporter.
// The slave modport is the controller side; the master modport is the engine/host side.
interface ga_run_controller_if #(
    parameter int POP_W = 7500,
    parameter int GEN_W = 16,
    parameter int FIT_W = 16
);
    logic             start;
    logic             abort;
    logic [GEN_W-1:0] max_gen;
    logic [FIT_W-1:0] target_fit;
    logic [FIT_W-1:0] best_fit;
    logic             best_fit_valid;
    logic [POP_W-1:0] in_pop;
    logic [POP_W-1:0] mut_pop;
    logic             in_done;
    logic             sel_done;
    logic             mut_done;
    logic [POP_W-1:0] population;
    logic             in_start;
    logic             sel_start;
    logic             mut_start;
    logic             uart_transmit;
    logic             busy;
    logic [2:0]       state_out;
    logic [GEN_W-1:0] gen_count;
    logic [1:0]       stop_reason;

    modport master (
        output start, abort, max_gen, target_fit, best_fit, best_fit_valid,
               in_pop, mut_pop, in_done, sel_done, mut_done,
        input  population, in_start, sel_start, mut_start, uart_transmit,
               busy, state_out, gen_count, stop_reason
    );

    modport slave (
        input  start, abort, max_gen, target_fit, best_fit, best_fit_valid,
               in_pop, mut_pop, in_done, sel_done, mut_done,
        output population, in_start, sel_start, mut_start, uart_transmit,
               busy, state_out, gen_count, stop_reason
    );
endinterface

// File: rtl/ga_run_controller.sv
// GA run sequencer: INIT -> (SELECT -> MUTATE)* -> REPORT, stopping on generation limit,
// fitness target or abort, holding the current population for the UART reporter.
module ga_run_controller #(
    parameter int POP_W = 7500,
    parameter int GEN_W = 16,
    parameter int FIT_W = 16
) (
    input logic              clk,
    input logic              rst_n,
    ga_run_controller_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT   = 3'd1,
        SELECT = 3'd2,
        MUTATE = 3'd3,
        REPORT = 3'd4
    } state_t;

    localparam logic [1:0] STOP_NONE  = 2'd0;
    localparam logic [1:0] STOP_MAX   = 2'd1;
    localparam logic [1:0] STOP_FIT   = 2'd2;
    localparam logic [1:0] STOP_ABORT = 2'd3;

    state_t           state_q,  state_d;
    logic [POP_W-1:0] pop_q,    pop_d;
    logic [GEN_W-1:0] gen_q,    gen_d;
    logic [GEN_W-1:0] limit_q,  limit_d;
    logic [FIT_W-1:0] target_q, target_d;
    logic [1:0]       stop_q,   stop_d;
    logic             fit_hit_q, fit_hit_d;
    logic             fit_seen;
    logic [GEN_W-1:0] gen_inc;

    assign fit_seen = bus.best_fit_valid && (bus.best_fit >= target_q);
    // gen_q stays below limit_q while running, so the increment never wraps.
    assign gen_inc  = gen_q + GEN_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pop_q     <= '0;
            gen_q     <= '0;
            limit_q   <= '0;
            target_q  <= '0;
            stop_q    <= STOP_NONE;
            fit_hit_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pop_q     <= pop_d;
            gen_q     <= gen_d;
            limit_q   <= limit_d;
            target_q  <= target_d;
            stop_q    <= stop_d;
            fit_hit_q <= fit_hit_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pop_d     = pop_q;
        gen_d     = gen_q;
        limit_d   = limit_q;
        target_d  = target_q;
        stop_d    = stop_q;
        fit_hit_d = fit_hit_q;

        case (state_q)
            IDLE, REPORT: begin
                if (bus.start) begin
                    state_d   = INIT;
                    limit_d   = (bus.max_gen == '0) ? GEN_W'(1) : bus.max_gen;
                    target_d  = bus.target_fit;
                    gen_d     = '0;
                    stop_d    = STOP_NONE;
                    fit_hit_d = 1'b0;
                end
            end
            INIT: begin
                if (bus.abort) begin
                    state_d = REPORT;
                    stop_d  = STOP_ABORT;
                end else if (bus.in_done) begin
                    pop_d   = bus.in_pop;
                    state_d = SELECT;
                end
            end
            SELECT: begin
                if (fit_seen) fit_hit_d = 1'b1;
                if (bus.abort) begin
                    state_d = REPORT;
                    stop_d  = STOP_ABORT;
                end else if (bus.sel_done) begin
                    state_d = MUTATE;
                end
            end
            MUTATE: begin
                if (fit_seen) fit_hit_d = 1'b1;
                if (bus.abort) begin
                    state_d = REPORT;
                    stop_d  = STOP_ABORT;
                end else if (bus.mut_done) begin
                    pop_d = bus.mut_pop;
                    gen_d = gen_inc;
                    // Decision uses the flag registered before this cycle; fitness outranks the limit.
                    if (fit_hit_q || (gen_inc >= limit_q)) begin
                        state_d = REPORT;
                        stop_d  = fit_hit_q ? STOP_FIT : STOP_MAX;
                    end else begin
                        state_d = SELECT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.population    = pop_q;
    assign bus.in_start      = (state_q == INIT);
    assign bus.sel_start     = (state_q == SELECT);
    assign bus.mut_start     = (state_q == MUTATE);
    assign bus.uart_transmit = (state_q == REPORT);
    assign bus.busy          = (state_q == INIT) || (state_q == SELECT) || (state_q == MUTATE);
    assign bus.state_out     = state_q;
    assign bus.gen_count     = gen_q;
    assign bus.stop_reason   = stop_q;
endmodule

// File: tb/tb_ga_run_controller.sv
// Scenario bench for ga_run_controller: a bench-side engine model answers the enables,
// and expected end-of-run results are queued at stimulus time and checked at REPORT.
module tb_ga_run_controller;
    localparam int PW = 64;
    localparam int GW = 16;
    localparam int FW = 16;
    localparam logic [PW-1:0] INIT_POP = 64'hFEED_0000_0000_BEEF;

    typedef struct {
        logic [GW-1:0] gen;
        logic [1:0]    reason;
        logic [PW-1:0] pop;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb[$];

    ga_run_controller_if #(.POP_W(PW), .GEN_W(GW), .FIT_W(FW)) bus ();

    ga_run_controller #(.POP_W(PW), .GEN_W(GW), .FIT_W(FW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PW-1:0] pop_fn(input int g);
        logic [31:0] a;
        a = g;
        return {a ^ 32'hC0DE_0000, ~a ^ 32'h5A5A_1234};
    endfunction

    // {in_start, sel_start, mut_start, uart_transmit, busy} for a given state
    function automatic logic [4:0] exp_vec(input int s);
        case (s)
            1:       return 5'b10001;
            2:       return 5'b01001;
            3:       return 5'b00101;
            4:       return 5'b00010;
            default: return 5'b00000;
        endcase
    endfunction

    task automatic clear_inputs();
        bus.start = 0; bus.abort = 0; bus.in_done = 0; bus.sel_done = 0; bus.mut_done = 0;
        bus.best_fit_valid = 0;
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        if (bus.state_out !== 3'd0 || bus.population !== '0 || bus.gen_count !== '0 ||
            bus.stop_reason !== 2'd0 || {bus.in_start, bus.sel_start, bus.mut_start,
            bus.uart_transmit, bus.busy} !== 5'b0) begin
            errors++;
            $display("FAIL %s: state=%0d pop=%h gen=%0d stop=%0d en=%b, required all zero", tag,
                     bus.state_out, bus.population, bus.gen_count, bus.stop_reason,
                     {bus.in_start, bus.sel_start, bus.mut_start, bus.uart_transmit, bus.busy});
        end
    endtask

    task automatic do_start(input logic [GW-1:0] mg, input logic [FW-1:0] tf);
        bus.start = 1; bus.max_gen = mg; bus.target_fit = tf;
        @(negedge clk);
        bus.start = 0;
        checks++;
        if (bus.state_out !== 3'd1 || bus.in_start !== 1'b1 || bus.gen_count !== '0 ||
            bus.stop_reason !== 2'd0) begin
            errors++;
            $display("FAIL start_to_init: state=%0d in_start=%b gen=%0d stop=%0d, required 1 1 0 0",
                     bus.state_out, bus.in_start, bus.gen_count, bus.stop_reason);
        end
    endtask

    // Engine model: answers each enable with a done pulse 2 cycles later, predicts every transition.
    task automatic drive_run(input int limit, input logic [FW-1:0] tf, input int fit_at,
                             input int abort_at);
        int   cnt, mcnt, exp_next, prev;
        bit   fit_m, finished;
        exp_t e;
        cnt = 0; mcnt = 0; exp_next = -1; prev = -1; fit_m = 0; finished = 0;
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            @(negedge clk);
            clear_inputs();
            if (exp_next >= 0) begin
                checks++;
                if (bus.state_out !== exp_next[2:0] || {bus.in_start, bus.sel_start, bus.mut_start,
                    bus.uart_transmit, bus.busy} !== exp_vec(exp_next)) begin
                    errors++;
                    $display("FAIL next_state: state=%0d en=%b, required state=%0d en=%b",
                             bus.state_out, {bus.in_start, bus.sel_start, bus.mut_start,
                             bus.uart_transmit, bus.busy}, exp_next, exp_vec(exp_next));
                end
                exp_next = -1;
            end
            if (bus.uart_transmit === 1'b1) begin
                finished = 1;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL report_unexpected: REPORT reached with empty scoreboard");
                end else begin
                    e = sb.pop_front();
                    if (bus.gen_count !== e.gen || bus.stop_reason !== e.reason ||
                        bus.population !== e.pop) begin
                        errors++;
                        $display("FAIL report_result: gen=%0d stop=%0d pop=%h, required gen=%0d stop=%0d pop=%h",
                                 bus.gen_count, bus.stop_reason, bus.population, e.gen, e.reason, e.pop);
                    end
                end
            end else begin
                if (bus.state_out != prev[2:0]) cnt = 0; else cnt++;
                prev = bus.state_out;
                case (bus.state_out)
                    3'd1: if (cnt == 2) begin
                        bus.in_pop = INIT_POP; bus.in_done = 1; exp_next = 2;
                    end
                    3'd2: begin
                        bus.best_fit_valid = 1;
                        bus.best_fit = (mcnt == fit_at) ? 16'h0050 : 16'h004F;
                        if (bus.best_fit >= tf) fit_m = 1;
                        if (cnt == 2) begin bus.sel_done = 1; exp_next = 3; end
                    end
                    3'd3: if (cnt == 2) begin
                        bus.mut_pop = pop_fn(mcnt + 1); bus.mut_done = 1;
                        if (mcnt + 1 == abort_at) begin
                            bus.abort = 1; exp_next = 4;
                        end else begin
                            mcnt++;
                            exp_next = (mcnt >= limit || fit_m) ? 4 : 2;
                        end
                    end
                    default: ;
                endcase
            end
        end
        if (!finished) begin
            checks++; errors++;
            $display("FAIL run_timeout: no REPORT within budget, state=%0d", bus.state_out);
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        clear_inputs();
        bus.max_gen = '0; bus.target_fit = '0; bus.best_fit = '0; bus.in_pop = '0; bus.mut_pop = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_state");
        rst_n = 1;
        @(negedge clk);
        check_idle_outputs("idle_after_reset");
    endtask

    task automatic test_max_gen();
        sb.push_back('{gen: 16'd3, reason: 2'd1, pop: pop_fn(3)});
        do_start(16'd3, 16'hFFFF);
        drive_run(3, 16'hFFFF, -1, -1);
    endtask

    task automatic test_max_gen_zero();
        sb.push_back('{gen: 16'd1, reason: 2'd1, pop: pop_fn(1)});
        do_start(16'd0, 16'hFFFF);
        drive_run(1, 16'hFFFF, -1, -1);
    endtask

    task automatic test_fitness();
        sb.push_back('{gen: 16'd5, reason: 2'd2, pop: pop_fn(5)});
        do_start(16'd100, 16'h0050);
        drive_run(100, 16'h0050, 4, -1);
    endtask

    task automatic test_abort();
        sb.push_back('{gen: 16'd1, reason: 2'd3, pop: pop_fn(1)});
        do_start(16'd10, 16'hFFFF);
        drive_run(10, 16'hFFFF, -1, 2);
    endtask

    task automatic test_ignored_and_restart();
        logic [GW-1:0] g;
        logic [1:0]    r;
        do_start(16'd2, 16'hFFFF);
        bus.start = 1; bus.sel_done = 1; bus.mut_done = 1;
        @(negedge clk);
        clear_inputs();
        checks++;
        if (bus.state_out !== 3'd1 || bus.gen_count !== '0) begin
            errors++;
            $display("FAIL ignored_in_init: state=%0d gen=%0d, required 1 0", bus.state_out, bus.gen_count);
        end
        sb.push_back('{gen: 16'd2, reason: 2'd1, pop: pop_fn(2)});
        drive_run(2, 16'hFFFF, -1, -1);
        g = bus.gen_count; r = bus.stop_reason;
        bus.abort = 1; bus.mut_done = 1;
        repeat (3) @(negedge clk);
        clear_inputs();
        checks++;
        if (bus.uart_transmit !== 1'b1 || bus.gen_count !== 16'd2 || bus.stop_reason !== 2'd1 ||
            bus.population !== pop_fn(2)) begin
            errors++;
            $display("FAIL report_hold: uart=%b gen=%0d stop=%0d pop=%h, required 1 %0d %0d %h",
                     bus.uart_transmit, bus.gen_count, bus.stop_reason, bus.population, g, r, pop_fn(2));
        end
        sb.push_back('{gen: 16'd1, reason: 2'd1, pop: pop_fn(1)});
        do_start(16'd1, 16'hFFFF);
        drive_run(1, 16'hFFFF, -1, -1);
    endtask

    task automatic test_reset_midrun();
        do_start(16'd5, 16'hFFFF);
        bus.in_pop = INIT_POP; bus.in_done = 1;
        @(negedge clk);
        clear_inputs();
        bus.sel_done = 1;
        @(negedge clk);
        clear_inputs();
        checks++;
        if (bus.state_out !== 3'd3 || bus.population !== INIT_POP) begin
            errors++;
            $display("FAIL reach_mutate: state=%0d pop=%h, required 3 %h", bus.state_out,
                     bus.population, INIT_POP);
        end
        rst_n = 0;
        #1;
        check_idle_outputs("async_reset_midrun");
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check_idle_outputs("idle_after_midrun_reset");
        sb.push_back('{gen: 16'd2, reason: 2'd1, pop: pop_fn(2)});
        do_start(16'd2, 16'hFFFF);
        drive_run(2, 16'hFFFF, -1, -1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_max_gen();
        test_max_gen_zero();
        test_fitness();
        test_abort();
        test_ignored_and_restart();
        test_reset_midrun();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
